// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared state encoding and default width for the SAR search engine
package sar_search_pkg;

  localparam int unsigned SAR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FINISH = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_search8.sv
// rtl/sar_search8.sv - binary (successive approximation) search driving an external comparator
// Optional build macro: SAR_SEARCH_FLAGCHK_EN aborts with err=1 on non-one-hot comparator flags.
module sar_search8
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_less,
  input  logic             cmp_equal,
  input  logic             cmp_more,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       steps,
  output logic             err
);

  localparam logic [3:0] STEP_LIMIT = 4'(WIDTH + 1);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       steps_q, steps_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic flag_eq, flag_lt, flag_gt, bad_flags, no_flags;

  // Midpoint at WIDTH+1 bits so lo+hi never overflows.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  always_comb begin
    no_flags = !(cmp_less || cmp_equal || cmp_more);
    flag_eq  = cmp_equal;
`ifdef SAR_SEARCH_FLAGCHK_EN
    bad_flags = !({cmp_less, cmp_equal, cmp_more} inside {3'b100, 3'b010, 3'b001});
    flag_lt   = cmp_less;
    flag_gt   = cmp_more;
`else
    // Priority equal > less > more; an all-zero flag set counts as "more".
    bad_flags = 1'b0;
    flag_lt   = !cmp_equal && cmp_less;
    flag_gt   = (!cmp_equal && !cmp_less && cmp_more) || no_flags;
`endif
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          probe_d  = midpoint('0, '1);
          result_d = '0;
          steps_d  = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        steps_d = steps_q + 4'd1;
        if (bad_flags) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = '0;
          state_d  = FINISH;
        end else if (flag_eq) begin
          found_d  = 1'b1;
          result_d = probe_q;
          state_d  = FINISH;
        end else if (steps_d == STEP_LIMIT) begin
          state_d = FINISH;
        end else if (flag_lt) begin
          // Stepping below lo would wrap hi; an inconsistent comparator ends the search.
          if (probe_q == lo_q) begin
            state_d = FINISH;
          end else begin
            hi_d    = probe_q - 1'b1;
            probe_d = midpoint(lo_q, probe_q - 1'b1);
          end
        end else if (flag_gt) begin
          if (probe_q == hi_q) begin
            state_d = FINISH;
          end else begin
            lo_d    = probe_q + 1'b1;
            probe_d = midpoint(probe_q + 1'b1, hi_q);
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '1;
      probe_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign probe  = probe_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign found  = found_q;
  assign err    = err_q;
  assign busy   = (state_q == SEARCH);
  assign done   = (state_q == FINISH);

endmodule

// File: tb/tb_sar_search8.sv
// tb/tb_sar_search8.sv - directed self-checking bench for sar_search8 with a magnitude comparator model
module tb_sar_search8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cmp_less, cmp_equal, cmp_more;
  logic [7:0] probe, result;
  logic       busy, done, found, err;
  logic [3:0] steps;

  logic [7:0] target = 8'd0;
  int         force_mode = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         probes[16];
  int         np;
  int         done_cnt;

  int exp255[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
  int exp0[8]   = '{127, 63, 31, 15, 7, 3, 1, 0};

  always #5 clk = ~clk;

  // Mode 0: true comparator; 1: forced less; 2: less+more; 3: no flags.
  always_comb begin
    case (force_mode)
      0:       {cmp_less, cmp_equal, cmp_more} = {target < probe, target == probe, target > probe};
      1:       {cmp_less, cmp_equal, cmp_more} = 3'b100;
      2:       {cmp_less, cmp_equal, cmp_more} = 3'b101;
      default: {cmp_less, cmp_equal, cmp_more} = 3'b000;
    endcase
  end

  sar_search8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp_less  (cmp_less),
    .cmp_equal (cmp_equal),
    .cmp_more  (cmp_more),
    .probe     (probe),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .result    (result),
    .steps     (steps),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(output int n);
    int cyc;
    cyc = 0;
    n = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1 && n < 16) begin
        probes[n] = int'(probe);
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {31'd0, done}, 1);
  endtask

  task automatic run_search(input logic [7:0] tgt, input int mode, output int n);
    target = tgt;
    force_mode = mode;
    @(negedge clk);
    launch();
    collect(n);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_probe", {24'd0, probe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_found", {31'd0, found}, 0);
    check("rst_result", {24'd0, result}, 0);
    check("rst_steps", {28'd0, steps}, 0);
    check("rst_err", {31'd0, err}, 0);
    rst_n = 1'b1;

    // Midpoint hit on the first comparison, then results must hold.
    run_search(8'd127, 0, np);
    check("t127_nprobes", np, 1);
    check("t127_found", {31'd0, found}, 1);
    check("t127_result", {24'd0, result}, 127);
    check("t127_steps", {28'd0, steps}, 1);
    @(negedge clk);
    check("t127_done_1cyc", {31'd0, done}, 0);
    repeat (3) @(negedge clk);
    check("t127_hold_result", {24'd0, result}, 127);
    check("t127_hold_steps", {28'd0, steps}, 1);

    run_search(8'd255, 0, np);
    check("t255_nprobes", np, 9);
    for (int i = 0; i < 9; i++) check($sformatf("t255_probe%0d", i), probes[i], exp255[i]);
    check("t255_found", {31'd0, found}, 1);
    check("t255_result", {24'd0, result}, 255);
    check("t255_steps", {28'd0, steps}, 9);

    run_search(8'd0, 0, np);
    check("t0_nprobes", np, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t0_probe%0d", i), probes[i], exp0[i]);
    check("t0_found", {31'd0, found}, 1);
    check("t0_result", {24'd0, result}, 0);
    check("t0_steps", {28'd0, steps}, 8);

    run_search(8'd50, 1, np);
    check("less_found", {31'd0, found}, 0);
    check("less_result", {24'd0, result}, 0);
    check("less_steps", {28'd0, steps}, 8);
    check("less_last_probe", probes[7], 0);
    check("less_err", {31'd0, err}, 0);

    run_search(8'd50, 2, np);
`ifdef SAR_SEARCH_FLAGCHK_EN
    check("both_err", {31'd0, err}, 1);
    check("both_steps", {28'd0, steps}, 1);
    check("both_found", {31'd0, found}, 0);
`else
    check("both_err", {31'd0, err}, 0);
    check("both_steps", {28'd0, steps}, 8);
    check("both_found", {31'd0, found}, 0);
`endif

    run_search(8'd50, 3, np);
`ifdef SAR_SEARCH_FLAGCHK_EN
    check("zero_err", {31'd0, err}, 1);
    check("zero_steps", {28'd0, steps}, 1);
`else
    check("zero_err", {31'd0, err}, 0);
    check("zero_steps", {28'd0, steps}, 9);
    check("zero_found", {31'd0, found}, 0);
    check("zero_last_probe", probes[8], 255);
`endif

    // Establish nonzero outputs, then reset on the 4th SEARCH cycle.
    run_search(8'd127, 0, np);
    target = 8'd10;
    force_mode = 0;
    @(negedge clk);
    launch();
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("arst_probe", {24'd0, probe}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_found", {31'd0, found}, 0);
    check("arst_result", {24'd0, result}, 0);
    check("arst_steps", {28'd0, steps}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_err", {31'd0, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    target = 8'd200;
    launch();
    check("accept_after_rst", {31'd0, busy}, 1);
    collect(np);
    check("t200_found", {31'd0, found}, 1);
    check("t200_result", {24'd0, result}, 200);
    check("t200_steps", {28'd0, steps}, 8);

    // Start during SEARCH must be ignored.
    target = 8'd1;
    @(negedge clk);
    launch();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    check("ignore_done_count", done_cnt, 1);
    check("ignore_result", {24'd0, result}, 1);
    check("ignore_steps", {28'd0, steps}, 7);
    check("ignore_busy", {31'd0, busy}, 0);

    // Held start relaunches from IDLE right after FINISH.
    target = 8'd127;
    start = 1'b1;
    @(negedge clk);
    check("held_busy1", {31'd0, busy}, 1);
    @(negedge clk);
    check("held_done", {31'd0, done}, 1);
    @(negedge clk);
    check("held_idle", {31'd0, busy | done}, 0);
    @(negedge clk);
    check("held_relaunch", {31'd0, busy}, 1);
    start = 1'b0;
    collect(np);
    check("held_found", {31'd0, found}, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_search8.md
SAR_SEARCH8 -- requirements
Module: sar_search8

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the search space, probe and result.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request a new search; sampled only in IDLE.
REQ-005 SHALL have port cmp_less, input, 1: external comparator result, target < probe.
REQ-006 SHALL have port cmp_equal, input, 1: external comparator result, target == probe.
REQ-007 SHALL have port cmp_more, input, 1: external comparator result, target > probe.
REQ-008 SHALL have port probe, output, WIDTH: registered candidate value driven to the external comparator.
REQ-009 SHALL have port busy, output, 1: high in SEARCH state.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a search ends.
REQ-011 SHALL have port found, output, 1: last search ended on cmp_equal.
REQ-012 SHALL have port result, output, WIDTH: probe value at the equal hit; 0 if not found.
REQ-013 SHALL have port steps, output, 4: number of comparisons used by the last search.
REQ-014 SHALL have port err, output, 1: last search aborted on a flag violation (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, SEARCH and FINISH; transitions are IDLE->SEARCH on start, SEARCH->FINISH on terminate, and FINISH->IDLE unconditionally.
REQ-016 SHALL, on start in IDLE, load lo=0 and hi=2^WIDTH-1, set probe=floor((lo+hi)/2) computed at WIDTH+1 bits (127 for WIDTH=8), clear steps, found, err and result, and enter SEARCH.
REQ-017 SHALL, in each SEARCH cycle, sample the flags against the current probe, increment steps, and issue exactly one comparison per cycle.
REQ-018 SHALL terminate on cmp_equal, setting found=1 and result=probe.
REQ-019 SHALL, on cmp_more, set lo=probe+1 and probe=new midpoint.
REQ-020 SHALL, on cmp_less, set hi=probe-1 and probe=new midpoint.
REQ-021 SHALL, as a boundary guard, terminate with found=0 and never wrap lo/hi when cmp_less arrives with probe==lo or cmp_more arrives with probe==hi.
REQ-022 SHALL terminate with found=0 when steps reaches WIDTH+1 (9) without equal; a consistent comparator always hits within WIDTH+1 comparisons.
REQ-023 SHALL assert done for exactly one cycle, in FINISH; busy SHALL be low in FINISH.
REQ-024 SHALL hold result, found, steps and err stable from FINISH until the next accepted start.
REQ-025 SHALL ignore start while in SEARCH or FINISH, with no queuing; start held high SHALL relaunch from IDLE the cycle after FINISH.

Reset
REQ-026 SHALL, while rst_n is low, immediately force state=IDLE and probe, result, steps, lo, found, busy, done and err to 0, and hi to all ones, including when reset occurs mid-search.
REQ-027 SHALL accept start the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with SAR_SEARCH_FLAGCHK_EN defined, treat any SEARCH cycle whose flags are not exactly one-hot as a terminating abort with err=1, found=0 and result=0.
REQ-029 SHALL, without SAR_SEARCH_FLAGCHK_EN, resolve flags by priority equal > less > more, treat all-zero as cmp_more, and tie err to 0.

Structure
REQ-030 SHALL take the state enum and default WIDTH constant from shared package sar_search_pkg.
REQ-031 SHALL be a single module with no sub-module; the comparator is external and the bench supplies an 8-bit magnitude comparator model fed by probe and a target register.

Verification
REQ-032 SHALL verify: target=127, start pulse -> done after 1 SEARCH cycle, found=1, result=127, steps=1.
REQ-033 SHALL verify: target=255 -> probes 127,191,223,239,247,251,253,254,255, then found=1, steps=9.
REQ-034 SHALL verify: target=0 -> probes 127,63,31,15,7,3,1,0, then found=1, steps=8, with no wrap of hi.
REQ-035 SHALL verify: forced cmp_less on every cycle -> terminate at probe==lo=0 with found=0 and result=0; with FLAGCHK_EN, forcing cmp_less and cmp_more together -> err=1 after 1 step.
REQ-036 SHALL verify: rst_n pulsed low on the 4th SEARCH cycle -> all outputs 0 asynchronously; a new start with target=200 -> found=1, result=200.
REQ-037 SHALL verify: start asserted during SEARCH -> ignored, with exactly one done pulse per accepted start.
